// File: rtl/black_bean_pkg.sv
// Shared definitions for the black_bean 8-bit accumulator-style CPU:
// datapath width, opcode encodings and FSM state codes.
package black_bean_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_MOV  = 4'h4,
    OP_ADD  = 4'h5,
    OP_SUB  = 4'h6,
    OP_AND  = 4'h7,
    OP_OR   = 4'h8,
    OP_XOR  = 4'h9,
    OP_NOT  = 4'hA,
    OP_SHL  = 4'hB,
    OP_JMP  = 4'hC,
    OP_JZ   = 4'hD,
    OP_JC   = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_OPER  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Opcodes that update Z and C.
  function automatic logic sets_flags(input opcode_t op);
    return (op >= OP_ADD) && (op <= OP_SHL);
  endfunction

endpackage

// File: rtl/black_bean_alu.sv
// bb_alu: combinational ALU for black_bean.
//   op     : opcode (selects operation)
//   a      : R[rd] operand
//   b      : R[rs] operand
//   result : operation result
//   z      : result == 0
//   c      : carry-out (ADD), borrow (SUB), old bit 7 (SHL), else 0
module bb_alu
  import black_bean_pkg::*;
#(
  parameter int DATA_WIDTH = black_bean_pkg::DATA_WIDTH
) (
  input  opcode_t               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  z,
  output logic                  c
);

  logic [DATA_WIDTH:0] wide;

  always_comb begin
    result = a;
    c      = 1'b0;
    wide   = '0;
    case (op)
      OP_MOV: result = b;
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_WIDTH-1:0];
        c      = wide[DATA_WIDTH];
      end
      OP_SUB: begin
        // The extra MSB of the difference is set exactly when a < b.
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DATA_WIDTH-1:0];
        c      = wide[DATA_WIDTH];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[DATA_WIDTH-2:0], 1'b0};
        c      = a[DATA_WIDTH-1];
      end
      default: result = a;
    endcase
    z = (result == '0);
  end

endmodule

// File: rtl/regfile.sv
// regfile: 2^DATA_WIDTH x DATA_WIDTH program/data memory for black_bean.
//   clk        : write clock
//   i_data     : write data
//   i_address  : shared read/write address
//   i_write_en : write strobe (rising clk)
//   o_data     : combinational read of reg_stored_data[i_address]
// Storage is never cleared so a program loaded during reset survives it;
// for that reason the block has no reset input.
module regfile #(
  parameter int DATA_WIDTH = black_bean_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [DATA_WIDTH-1:0] i_address,
  input  logic                  i_write_en,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] reg_stored_data [2**DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (i_write_en) reg_stored_data[i_address] <= i_data;
  end

  assign o_data = reg_stored_data[i_address];

endmodule

// File: rtl/black_bean.sv
// black_bean: multi-cycle 8-bit CPU (FETCH / EXEC / OPER / HALT).
//   clk, rst_n  : clock, asynchronous active-low reset
//   mem_r_data  : memory read data (combinational from address)
//   mem_r_addr  : read address
//   mem_r_en    : read strobe
//   mem_w_data  : write data
//   mem_w_addr  : write address
//   mem_w_en    : write strobe (never together with mem_r_en)
module black_bean #(
  parameter int DATA_WIDTH = black_bean_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] mem_r_data,
  output logic [DATA_WIDTH-1:0] mem_r_addr,
  output logic                  mem_r_en,
  output logic [DATA_WIDTH-1:0] mem_w_data,
  output logic [DATA_WIDTH-1:0] mem_w_addr,
  output logic                  mem_w_en
);
  import black_bean_pkg::*;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] ir;
  logic [DATA_WIDTH-1:0] regs [4];
  logic                  flag_z, flag_c;

  opcode_t               op;
  logic [1:0]            rd, rs;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_z, alu_c;

  assign op = opcode_t'(ir[7:4]);
  assign rd = ir[3:2];
  assign rs = ir[1:0];

  bb_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op     (op),
    .a      (regs[rd]),
    .b      (regs[rs]),
    .result (alu_result),
    .z      (alu_z),
    .c      (alu_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_FETCH: state_nx = ST_EXEC;
      ST_EXEC: begin
        case (op)
          OP_LDI, OP_JMP, OP_JZ, OP_JC: state_nx = ST_OPER;
          OP_HALT:                      state_nx = ST_HALT;
          default:                      state_nx = ST_FETCH;
        endcase
      end
      ST_OPER: state_nx = ST_FETCH;
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_FETCH;
    endcase
  end

  // Output logic. The reset state is FETCH, whose decode would raise the
  // read strobe, so outputs are additionally forced idle while rst_n is low.
  always_comb begin
    mem_r_en   = 1'b0;
    mem_r_addr = '0;
    mem_w_en   = 1'b0;
    mem_w_addr = '0;
    mem_w_data = '0;
    if (rst_n) begin
      case (state)
        ST_FETCH: begin
          mem_r_en   = 1'b1;
          mem_r_addr = pc;
        end
        ST_EXEC: begin
          if (op == OP_LD) begin
            mem_r_en   = 1'b1;
            mem_r_addr = regs[rs];
          end else if (op == OP_ST) begin
            mem_w_en   = 1'b1;
            mem_w_addr = regs[rd];
            mem_w_data = regs[rs];
          end
        end
        ST_OPER: begin
          mem_r_en   = 1'b1;
          mem_r_addr = pc;
        end
        default: ;
      endcase
    end
  end

  // Architectural state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= '0;
      ir     <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          ir <= mem_r_data;
          pc <= pc + 1'b1;
        end
        ST_EXEC: begin
          case (op)
            OP_LD: regs[rd] <= mem_r_data;
            OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOT, OP_SHL: regs[rd] <= alu_result;
            default: ;
          endcase
          if (sets_flags(op)) begin
            flag_z <= alu_z;
            flag_c <= alu_c;
          end
        end
        ST_OPER: begin
          case (op)
            OP_LDI: begin
              regs[rd] <= mem_r_data;
              pc       <= pc + 1'b1;
            end
            OP_JMP: pc <= mem_r_data;
            OP_JZ:  pc <= flag_z ? mem_r_data : pc + 1'b1;
            OP_JC:  pc <= flag_c ? mem_r_data : pc + 1'b1;
            default: pc <= pc + 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_black_bean.sv
module tb_black_bean;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] mem_r_data, mem_r_addr, mem_w_data, mem_w_addr;
  logic       mem_r_en, mem_w_en;

  // Bench-side preload path into the memory while the CPU is in reset.
  logic       ld_mode, ld_we;
  logic [7:0] ld_addr, ld_data;
  logic [7:0] mem_addr, mem_data;
  logic       mem_we;

  int checks = 0;
  int errors = 0;

  // Instruction-level reference model
  logic [7:0] m_mem [256];
  logic [7:0] m_pc;
  logic [7:0] m_r [4];
  logic       m_z, m_c, m_halt;

  always #5 clk = ~clk;

  always_comb begin
    if (ld_mode) begin
      mem_addr = ld_addr;
      mem_data = ld_data;
      mem_we   = ld_we;
    end else begin
      mem_addr = mem_r_en ? mem_r_addr : mem_w_addr;
      mem_data = mem_w_data;
      mem_we   = mem_w_en;
    end
  end

  black_bean #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_r_data (mem_r_data),
    .mem_r_addr (mem_r_addr),
    .mem_r_en   (mem_r_en),
    .mem_w_data (mem_w_data),
    .mem_w_addr (mem_w_addr),
    .mem_w_en   (mem_w_en)
  );

  regfile #(.DATA_WIDTH(8)) mem (
    .clk        (clk),
    .i_data     (mem_data),
    .i_address  (mem_addr),
    .i_write_en (mem_we),
    .o_data     (mem_r_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check one bus cycle, then advance past the next rising edge.
  task automatic cyc(input logic er, input logic [7:0] ra, input logic ew,
                     input logic [7:0] wa, input logic [7:0] wd, input string tag);
    chk({tag, "_r_en"},   mem_r_en,   er);
    chk({tag, "_r_addr"}, mem_r_addr, ra);
    chk({tag, "_w_en"},   mem_w_en,   ew);
    chk({tag, "_w_addr"}, mem_w_addr, wa);
    chk({tag, "_w_data"}, mem_w_data, wd);
    chk({tag, "_excl"},   mem_r_en & mem_w_en, 0);
    @(posedge clk); #1;
  endtask

  function automatic void ref_alu(input logic [3:0] op, input int a, input int b,
                                  output logic [7:0] res, output logic z, output logic c);
    int r;
    c = 1'b0;
    case (op)
      4'h4: r = b;
      4'h5: begin r = a + b; c = (r > 255); end
      4'h6: begin r = a - b; c = (a < b); end
      4'h7: r = a & b;
      4'h8: r = a | b;
      4'h9: r = a ^ b;
      4'hA: r = 255 - a;
      4'hB: begin r = a * 2; c = (a >= 128); end
      default: r = a;
    endcase
    res = r[7:0];
    z = (res == 8'h00);
  endfunction

  task automatic model_reset();
    m_pc = 8'h00; m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
  endtask

  // Execute one instruction of the model, checking its bus trace cycle by cycle.
  task automatic step();
    logic [7:0] ir, imm, res;
    logic [3:0] op;
    logic [1:0] rd, rs;
    logic       z, c;
    if (m_halt) begin
      cyc(0, 0, 0, 0, 0, "halt");
      return;
    end
    cyc(1, m_pc, 0, 0, 0, "fetch");
    ir = m_mem[m_pc];
    m_pc = m_pc + 8'd1;
    op = ir[7:4]; rd = ir[3:2]; rs = ir[1:0];
    case (op)
      4'h0: cyc(0, 0, 0, 0, 0, "nop");
      4'h2: begin
        cyc(1, m_r[rs], 0, 0, 0, "ld");
        m_r[rd] = m_mem[m_r[rs]];
      end
      4'h3: begin
        cyc(0, 0, 1, m_r[rd], m_r[rs], "st");
        m_mem[m_r[rd]] = m_r[rs];
      end
      4'h1, 4'hC, 4'hD, 4'hE: begin
        cyc(0, 0, 0, 0, 0, "exec");
        cyc(1, m_pc, 0, 0, 0, "oper");
        imm = m_mem[m_pc];
        if (op == 4'h1) m_r[rd] = imm;
        if (op == 4'hC || (op == 4'hD && m_z) || (op == 4'hE && m_c)) m_pc = imm;
        else m_pc = m_pc + 8'd1;
      end
      4'hF: begin
        cyc(0, 0, 0, 0, 0, "exec_halt");
        m_halt = 1'b1;
      end
      default: begin
        cyc(0, 0, 0, 0, 0, "alu");
        ref_alu(op, int'(m_r[rd]), int'(m_r[rs]), res, z, c);
        m_r[rd] = res;
        if (op >= 4'h5) begin m_z = z; m_c = c; end
      end
    endcase
  endtask

  task automatic check_arch(input string tag);
    chk({tag, "_pc"}, dut.pc, m_pc);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_r%0d", tag, i), dut.regs[i], m_r[i]);
    chk({tag, "_z"}, dut.flag_z, m_z);
    chk({tag, "_c"}, dut.flag_c, m_c);
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
  endtask

  // Hold reset, load the model image into memory, check idle outputs, release.
  task automatic load_and_start();
    rst_n = 1'b0;
    #1;
    ld_mode = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ld_addr = 8'(i); ld_data = m_mem[i]; ld_we = 1'b1;
      @(posedge clk); #1;
    end
    ld_we = 1'b0; ld_mode = 1'b0;
    #1;
    model_reset();
    chk("rst_r_en", mem_r_en, 0);
    chk("rst_w_en", mem_w_en, 0);
    chk("rst_r_addr", mem_r_addr, 0);
    chk("rst_w_addr", mem_w_addr, 0);
    chk("rst_w_data", mem_w_data, 0);
    check_arch("rst");
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ld_mode = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;

    // LDI R0,5; LDI R1,3; ADD R0,R1; ST [R1],R0; HALT
    clear_img();
    m_mem[0] = 8'h10; m_mem[1] = 8'h05; m_mem[2] = 8'h14; m_mem[3] = 8'h03;
    m_mem[4] = 8'h51; m_mem[5] = 8'h34; m_mem[6] = 8'hF0;
    load_and_start();
    for (int i = 0; i < 10; i++) step();
    chk("p1_mem03", mem.reg_stored_data[8'h03], 8'h08);
    chk("p1_z", dut.flag_z, 1'b0);
    chk("p1_c", dut.flag_c, 1'b0);
    check_arch("p1");

    // LDI R0,FF; LDI R1,1; ADD R0,R1; JC 0x20 -> HALT at 0x20
    clear_img();
    m_mem[0] = 8'h10; m_mem[1] = 8'hFF; m_mem[2] = 8'h14; m_mem[3] = 8'h01;
    m_mem[4] = 8'h51; m_mem[5] = 8'hE0; m_mem[6] = 8'h20; m_mem[8'h20] = 8'hF0;
    load_and_start();
    for (int i = 0; i < 4; i++) step();
    chk("p2_pc", dut.pc, 8'h20);
    chk("p2_r0", dut.regs[0], 8'h00);
    chk("p2_z", dut.flag_z, 1'b1);
    chk("p2_c", dut.flag_c, 1'b1);
    for (int i = 0; i < 3; i++) step();
    check_arch("p2");

    // LDI R2,0x40; LD R3,[R2]; SHL R3; HALT with mem[0x40]=A5
    clear_img();
    m_mem[0] = 8'h18; m_mem[1] = 8'h40; m_mem[2] = 8'h2E; m_mem[3] = 8'hBC;
    m_mem[4] = 8'hF0; m_mem[8'h40] = 8'hA5;
    load_and_start();
    for (int i = 0; i < 6; i++) step();
    chk("p3_r3", dut.regs[3], 8'h4A);
    chk("p3_c", dut.flag_c, 1'b1);
    chk("p3_z", dut.flag_z, 1'b0);
    check_arch("p3");

    // SUB R0,R0; JZ 0x10 (taken); LDI R1,5; XOR R1,R0; JZ 0x40 (not taken); HALT
    clear_img();
    m_mem[0] = 8'h60; m_mem[1] = 8'hD0; m_mem[2] = 8'h10;
    m_mem[8'h10] = 8'h14; m_mem[8'h11] = 8'h05; m_mem[8'h12] = 8'h94;
    m_mem[8'h13] = 8'hD0; m_mem[8'h14] = 8'h40; m_mem[8'h15] = 8'hF0;
    load_and_start();
    for (int i = 0; i < 2; i++) step();
    chk("p4_jz_taken_pc", dut.pc, 8'h10);
    for (int i = 0; i < 3; i++) step();
    chk("p4_jz_not_taken_pc", dut.pc, 8'h15);
    for (int i = 0; i < 3; i++) step();
    check_arch("p4");

    // Reset during a ST execute cycle: no write, idle outputs, refetch at 0.
    clear_img();
    m_mem[0] = 8'h14; m_mem[1] = 8'h30; m_mem[2] = 8'h10; m_mem[3] = 8'h77;
    m_mem[4] = 8'h34; m_mem[5] = 8'hF0; m_mem[8'h30] = 8'h5A;
    load_and_start();
    for (int i = 0; i < 2; i++) step();
    cyc(1, 8'h04, 0, 0, 0, "p5_fetch_st");
    chk("p5_st_w_en", mem_w_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("p5_rst_w_en", mem_w_en, 0);
    chk("p5_rst_r_en", mem_r_en, 0);
    chk("p5_rst_w_addr", mem_w_addr, 0);
    chk("p5_rst_w_data", mem_w_data, 0);
    @(posedge clk); #1;
    chk("p5_mem30_kept", mem.reg_stored_data[8'h30], 8'h5A);
    model_reset();
    check_arch("p5_rst");
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) step();
    chk("p5_mem30_after", mem.reg_stored_data[8'h30], 8'h77);
    check_arch("p5");

    // Random programs against the instruction-level model.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 256; i++) begin
        m_mem[i] = 8'($urandom);
        if (m_mem[i][7:4] == 4'hF && $urandom_range(0, 7) != 0) m_mem[i][7:4] = 4'h5;
      end
      load_and_start();
      for (int i = 0; i < 150; i++) step();
      check_arch($sformatf("rnd%0d", p));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
